// File: rtl/exhaustive_bist_ctrl_pkg.sv
// Shared definitions for the exhaustive truth-table BIST controller:
// FSM state encoding, MISR feedback polynomial and counter sizing helper.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } bist_state_e;

  // CCITT polynomial x^16 + x^12 + x^5 + 1 (x^16 term implied by the shift-out)
  localparam logic [15:0] POLY = 16'h1021;

  function automatic int cnt_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/exhaustive_bist_ctrl_if.sv
// Bus between the BIST controller and its environment: run control, the
// stimulus/response pair towards the DUT under test, and result reporting.
interface exhaustive_bist_ctrl_if #(
  parameter int NIN   = 4,
  parameter int NOUT  = 2,
  parameter int SIG_W = 16
) ();

  logic             start;
  logic [NIN-1:0]   vec;
  logic [NOUT-1:0]  resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  // master: the environment (host plus the combinational DUT); slave: the controller
  modport master (
    output start, resp,
    input  vec, busy, done, pass, signature
  );

  modport slave (
    input  start, resp,
    output vec, busy, done, pass, signature
  );

endinterface

// File: rtl/exhaustive_bist_ctrl_misr.sv
// Multiple-input signature register: shifts left with POLY feedback from the
// MSB and XORs the zero-extended response word in on every enabled clock.
module misr_reg
  import bist_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int NOUT  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [NOUT-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_reg;
  logic [SIG_W-1:0] sig_next;

  genvar gi;
  generate
    for (gi = 0; gi < SIG_W; gi++) begin : g_bit
      logic shift_in;
      logic poly_bit;
      logic data_bit;

      if (gi == 0) begin : g_lsb
        assign shift_in = 1'b0;
      end else begin : g_mid
        assign shift_in = sig_reg[gi-1];
      end

      // POLY is 16 bits wide; wider signatures get no taps above bit 15
      if (gi < $bits(POLY)) begin : g_tap
        assign poly_bit = POLY[gi];
      end else begin : g_notap
        assign poly_bit = 1'b0;
      end

      if (gi < NOUT) begin : g_din
        assign data_bit = din[gi];
      end else begin : g_nodin
        assign data_bit = 1'b0;
      end

      assign sig_next[gi] = shift_in ^ (sig_reg[SIG_W-1] & poly_bit) ^ data_bit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      sig_reg <= '0;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/exhaustive_bist_ctrl.sv
// Exhaustive BIST controller: walks every NIN-bit code, holds each for HOLD
// clocks, folds the sampled response into a MISR and compares to GOLDEN.
module exhaustive_bist_ctrl
  import bist_pkg::*;
#(
  parameter int               NIN    = 4,
  parameter int               NOUT   = 2,
  parameter int               HOLD   = 20,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input logic                  clk,
  input logic                  rst,
  exhaustive_bist_ctrl_if.slave bus
);

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_APPLY = APPLY;
  localparam logic [1:0]       ST_DONE  = DONE;
  localparam int               CNT_W    = cnt_width(HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [NIN-1:0]   VEC_LAST = '1;

  logic [1:0]       state_reg, state_next;
  logic [NIN-1:0]   vec_reg, vec_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_run;
  logic             capture;
  logic [SIG_W-1:0] sig;

  assign start_run = bus.start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  // the last clock of each hold window is the sampling point for resp
  assign capture   = (state_reg == ST_APPLY) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next = ST_APPLY;
          vec_next   = '0;
          cnt_next   = '0;
        end
      end
      ST_APPLY: begin
        if (capture) begin
          cnt_next = '0;
          if (vec_reg == VEC_LAST) begin
            state_next = ST_DONE;
            vec_next   = '0;
          end else begin
            vec_next = vec_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        vec_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      vec_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      cnt_reg   <= cnt_next;
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .NOUT  (NOUT)
  ) u_misr (
    .clk (clk),
    .clr (rst | start_run),
    .en  (capture),
    .din (bus.resp),
    .sig (sig)
  );

  assign bus.vec       = vec_reg;
  assign bus.busy      = (state_reg == ST_APPLY);
  assign bus.done      = (state_reg == ST_DONE);
  assign bus.pass      = (state_reg == ST_DONE) && (sig == GOLDEN);
  assign bus.signature = sig;

endmodule

// File: tb/tb_exhaustive_bist_ctrl.sv
// Bench for exhaustive_bist_ctrl: a run-time based reference model for the
// HOLD=20 instance plus directed literal checks on three fixed-response instances.
module tb_exhaustive_bist_ctrl;

  localparam int H0 = 20;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'd0, d};
  endfunction

  function automatic logic [1:0] func_resp(input int code);
    logic a, b, c, d, f;
    a = code[3]; b = code[2]; c = code[1]; d = code[0];
    f = (a & b) | (c & d);
    return {f, ~f};
  endfunction

  function automatic logic [15:0] func_golden();
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < 16; i++) s = misr_step(s, func_resp(i));
    return s;
  endfunction

  localparam logic [15:0] GOLD_FUNC = func_golden();

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exhaustive_bist_ctrl_if #(.NIN(4), .NOUT(2), .SIG_W(16)) if0 ();
  exhaustive_bist_ctrl_if #(.NIN(4), .NOUT(2), .SIG_W(16)) if1 ();
  exhaustive_bist_ctrl_if #(.NIN(4), .NOUT(2), .SIG_W(16)) if2 ();
  exhaustive_bist_ctrl_if #(.NIN(4), .NOUT(2), .SIG_W(16)) if3 ();

  exhaustive_bist_ctrl #(.NIN(4), .NOUT(2), .HOLD(H0), .SIG_W(16), .GOLDEN(GOLD_FUNC))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  exhaustive_bist_ctrl #(.NIN(4), .NOUT(2), .HOLD(1), .SIG_W(16), .GOLDEN(16'hFFFF))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  exhaustive_bist_ctrl #(.NIN(4), .NOUT(2), .HOLD(1), .SIG_W(16), .GOLDEN(16'h0000))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  exhaustive_bist_ctrl #(.NIN(4), .NOUT(2), .HOLD(H0), .SIG_W(16), .GOLDEN(16'h0000))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  // truth table of the emulated combinational DUT beside u0
  logic [1:0] tt [16];
  assign if0.resp = tt[if0.vec];
  assign if1.resp = 2'b01;
  assign if2.resp = 2'b01;
  assign if3.resp = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference model of u0: tracks elapsed clocks since the start edge
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_sig = 16'h0000;
  int          m_cyc = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; m_sig = 16'h0000; m_cyc = 0;
    end else if (!m_run) begin
      if (if0.start) begin
        m_run = 1'b1; m_done = 1'b0; m_sig = 16'h0000; m_cyc = 0;
      end
    end else begin
      if ((m_cyc + 1) % H0 == 0) begin
        m_sig = misr_step(m_sig, tt[m_cyc / H0]);
        if (m_cyc + 1 == 16 * H0) begin
          m_run = 1'b0; m_done = 1'b1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0]  e_vec;
      logic        e_pass;
      e_vec  = m_run ? 4'(m_cyc / H0) : 4'd0;
      e_pass = m_done && (m_sig == GOLD_FUNC);
      n_cmp++;
      if ({if0.vec, if0.busy, if0.done, if0.pass, if0.signature} !==
          {e_vec, m_run, m_done, e_pass, m_sig}) begin
        n_bad++;
        $display("FAIL model t=%0t got vec=%0h busy=%b done=%b pass=%b sig=%h expected vec=%0h busy=%b done=%b pass=%b sig=%h",
                 $time, if0.vec, if0.busy, if0.done, if0.pass, if0.signature,
                 e_vec, m_run, m_done, e_pass, m_sig);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_done0(input int budget);
    int n;
    n = 0;
    while (!if0.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!if0.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: got done=0 after %0d clocks expected done=1", budget);
    end
  endtask

  task automatic pulse_start0();
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic random_tt();
    for (int i = 0; i < 16; i++) tt[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
    for (int i = 0; i < 16; i++) tt[i] = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_state", {if0.vec, if0.busy, if0.done, if0.pass, if0.signature}, 32'h0);

    // u3: resp 00, HOLD 20, GOLDEN 0 -- vector ordering and exact latency
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int j = 0; j < 16 * H0; j++) begin
      chk($sformatf("u3_run_j%0d", j), {if3.busy, if3.done, if3.vec}, {2'b10, 4'(j / H0)});
      @(negedge clk);
    end
    chk("u3_done_busy", {if3.busy, if3.done}, 2'b01);
    chk("u3_signature", if3.signature, 16'h0000);
    chk("u3_pass", if3.pass, 1'b1);
    chk("u3_vec_end", if3.vec, 4'h0);

    // u1/u2: resp 01, HOLD 1 -- signature ramps 0001..FFFF
    if1.start = 1'b1; if2.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0; if2.start = 1'b0;
    chk("u1_first", {if1.busy, if1.signature}, {1'b1, 16'h0000});
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk($sformatf("u1_sig_%0d", j), if1.signature, (32'd1 << j) - 32'd1);
      chk($sformatf("u1_done_%0d", j), if1.done, (j == 16) ? 1 : 0);
    end
    chk("u1_pass", if1.pass, 1'b1);
    chk("u2_done", if2.done, 1'b1);
    chk("u2_pass", if2.pass, 1'b0);

    // u0: resp tied 01 at HOLD 20 pins the model signature too
    for (int i = 0; i < 16; i++) tt[i] = 2'b01;
    pulse_start0();
    wait_done0(400);
    chk("u0_ones_sig", if0.signature, 16'hFFFF);
    chk("model_ones_sig", m_sig, 16'hFFFF);

    // functional DUT f = ab | cd, f2 = ~f must pass
    for (int i = 0; i < 16; i++) tt[i] = func_resp(i);
    pulse_start0();
    wait_done0(400);
    chk("func_pass", if0.pass, 1'b1);

    // one flipped truth-table entry must fail
    begin
      int idx;
      idx = $urandom_range(0, 15);
      tt[idx][1] = ~tt[idx][1];
    end
    pulse_start0();
    wait_done0(400);
    chk("flip_pass", if0.pass, 1'b0);

    // reset 50 clocks into a run, then at random points
    for (int r = 0; r < 3; r++) begin
      random_tt();
      pulse_start0();
      repeat ((r == 0) ? 49 : $urandom_range(1, 300)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk($sformatf("midrun_rst_%0d", r),
          {if0.vec, if0.busy, if0.done, if0.pass, if0.signature}, 32'h0);
    end

    // start held high: no restart in APPLY, immediate restart from DONE
    random_tt();
    if0.start = 1'b1;
    @(negedge clk);
    wait_done0(400);
    @(negedge clk);
    chk("held_restart", {if0.busy, if0.done, if0.vec, if0.signature}, {2'b10, 4'h0, 16'h0000});
    if0.start = 1'b0;
    wait_done0(400);

    // randomized start/reset activity, checked by the model every cycle
    for (int r = 0; r < 4; r++) begin
      random_tt();
      for (int c = 0; c < 400; c++) begin
        if0.start = ($urandom_range(0, 99) < 10);
        rst = ($urandom_range(0, 999) < 3);
        @(negedge clk);
      end
    end
    if0.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
